// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the main control unit and muldiv_ctrl.
// The control unit is the master; the controller is the slave.
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        ready;
    logic        op_done;
    logic        div_zero_exc;
    logic        timeout_err;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  ready, op_done, div_zero_exc, timeout_err, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output ready, op_done, div_zero_exc, timeout_err, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multicycle multiplier/divider; owns HI/LO and
// reports divide-by-zero and hung-unit events back to control.
module muldiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_ctrl_if.slave       bus,
    output logic [31:0]        unit_a,
    output logic [31:0]        unit_b,
    output logic               div_start,
    input  logic               div_done,
    input  logic               div_zero,
    input  logic [31:0]        div_hi,
    input  logic [31:0]        div_lo,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [31:0]        mul_hi,
    input  logic [31:0]        mul_lo
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START_DIV,
        WAIT_DIV,
        START_MUL,
        WAIT_MUL,
        DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          ld_hi;
    logic          ld_lo;
    logic [31:0]   hi_d;
    logic [31:0]   lo_d;
    logic          ld_ops;
    logic          zero_d;
    logic          tmo_d;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          zero_q;
    logic          tmo_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        nxt     = state;
        ld_hi   = 1'b0;
        ld_lo   = 1'b0;
        hi_d    = bus.req_a;
        lo_d    = bus.req_a;
        ld_ops  = 1'b0;
        zero_d  = 1'b0;
        tmo_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    unique case (bus.req_op)
                        OP_MULT: begin
                            ld_ops = 1'b1;
                            nxt    = START_MUL;
                        end
                        OP_DIV: begin
                            ld_ops = 1'b1;
                            nxt    = START_DIV;
                        end
                        OP_MTHI: ld_hi = 1'b1;
                        OP_MTLO: ld_lo = 1'b1;
                    endcase
                end
            end
            // A level-held done from the previous op is ignored here.
            START_DIV: begin
                cnt_clr = 1'b1;
                nxt     = WAIT_DIV;
            end
            START_MUL: begin
                cnt_clr = 1'b1;
                nxt     = WAIT_MUL;
            end
            WAIT_DIV: begin
                if (div_zero) begin
                    zero_d = 1'b1;
                    nxt    = DONE;
                end else if (div_done) begin
                    ld_hi = 1'b1;
                    ld_lo = 1'b1;
                    hi_d  = div_hi;
                    lo_d  = div_lo;
                    nxt   = DONE;
                end else if (timed_out) begin
                    tmo_d = 1'b1;
                    nxt   = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_MUL: begin
                if (mul_done) begin
                    ld_hi = 1'b1;
                    ld_lo = 1'b1;
                    hi_d  = mul_hi;
                    lo_d  = mul_lo;
                    nxt   = DONE;
                end else if (timed_out) begin
                    tmo_d = 1'b1;
                    nxt   = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            unit_a <= '0;
            unit_b <= '0;
            zero_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= nxt;
            zero_q <= zero_d;
            tmo_q  <= tmo_d;
            if (ld_hi) hi_q <= hi_d;
            if (ld_lo) lo_q <= lo_d;
            if (ld_ops) begin
                unit_a <= bus.req_a;
                unit_b <= bus.req_b;
            end
            // Saturate rather than wrap.
            if (cnt_clr) cnt <= '0;
            else if (cnt_inc && cnt != '1) cnt <= cnt + CW'(1);
        end
    end

    assign bus.ready        = (state == IDLE);
    assign bus.op_done      = (state == DONE);
    assign bus.div_zero_exc = zero_q;
    assign bus.timeout_err  = tmo_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign div_start        = (state == START_DIV);
    assign mul_start        = (state == START_MUL);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and
// divider models of configurable latency.
module tb_muldiv_ctrl;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        div_start;
    logic        div_done;
    logic        div_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [63:0] prod;

    int div_lat = 33;
    int mul_lat = 32;
    bit zmode = 1'b0;
    int dcnt = 0;
    int mcnt = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.TIMEOUT(40)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .div_start (div_start),
        .div_done  (div_done),
        .div_zero  (div_zero),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_hi    (mul_hi),
        .mul_lo    (mul_lo)
    );

    // Unit models: done rises lat cycles after start and stays high.
    always @(posedge clk) begin
        if (reset) dcnt <= 0;
        else if (div_start) dcnt <= 1;
        else if (dcnt != 0 && dcnt < 1000) dcnt <= dcnt + 1;
        if (reset) mcnt <= 0;
        else if (mul_start) mcnt <= 1;
        else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
    end

    assign div_done = (div_lat != 0) && (dcnt >= div_lat);
    assign div_zero = zmode && (dcnt >= 1);
    assign div_lo = (unit_b == 32'd0) ? 32'd0 :
                    32'($signed(unit_a) / $signed(unit_b));
    assign div_hi = (unit_b == 32'd0) ? 32'd0 :
                    32'($signed(unit_a) % $signed(unit_b));
    assign mul_done = (mcnt != 0) && (mcnt >= mul_lat);
    assign prod = {{32{unit_a[31]}}, unit_a} * {{32{unit_b[31]}}, unit_b};
    assign mul_hi = prod[63:32];
    assign mul_lo = prod[31:0];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        int w;
        w = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        while (!bus.ready && w < 100) begin
            tick;
            w++;
        end
        if (!bus.ready) check("ready_wait", bus.ready, 1);
        tick;
        bus.req_valid = 1'b0;
    endtask

    task automatic mt(input logic [1:0] op, input logic [31:0] d,
                      input logic [31:0] ehi, input logic [31:0] elo);
        send(op, d, 32'd0);
        check("mt_hi", bus.hi, ehi);
        check("mt_lo", bus.lo, elo);
        check("mt_idle", {bus.ready, bus.op_done}, 2'b10);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic ez,
                          input logic et, input int ecyc, input bit noise);
        exp_t e;
        int   k;
        int   ds;
        int   ms;
        int   sk;
        bit   hold;
        e.hi = ehi;
        e.lo = elo;
        e.zero = ez;
        e.tmo = et;
        e.cyc = ecyc;
        sbq.push_back(e);
        send(op, a, b);
        k = 1;
        ds = 0;
        ms = 0;
        sk = 0;
        hold = 1'b1;
        while (!bus.op_done && k < 200) begin
            if (div_start) begin
                ds++;
                sk = k;
            end
            if (mul_start) begin
                ms++;
                sk = k;
            end
            if (unit_a !== a || unit_b !== b) hold = 1'b0;
            if (bus.div_zero_exc || bus.timeout_err) hold = 1'b0;
            if (noise && k == 5) begin
                bus.req_valid = 1'b1;
                bus.req_op    = OP_MTLO;
                bus.req_a     = 32'hDEAD;
            end
            if (noise && k == 8) bus.req_valid = 1'b0;
            tick;
            k++;
        end
        check("op_done_seen", bus.op_done, 1);
        e = sbq.pop_front();
        check("done_cycle", k, e.cyc);
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("div_zero_exc", bus.div_zero_exc, e.zero);
        check("timeout_err", bus.timeout_err, e.tmo);
        check("div_starts", ds, (op == OP_DIV) ? 1 : 0);
        check("mul_starts", ms, (op == OP_MULT) ? 1 : 0);
        check("start_cycle", sk, 1);
        check("operands_held", hold, 1);
        tick;
        check("post_done",
              {bus.ready, bus.op_done, bus.div_zero_exc, bus.timeout_err},
              4'b1000);
    endtask

    initial begin
        bit seen;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        reset = 1'b1;
        tick;
        tick;
        check("rst_ctl", {bus.ready, bus.op_done, bus.div_zero_exc,
                          bus.timeout_err, div_start, mul_start},
              6'b100000);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_units", {unit_a, unit_b}, 64'd0);
        reset = 1'b0;
        tick;

        div_lat = 33;
        run_op(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, 35, 0);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
               0, 0, 35, 0);

        mt(OP_MTHI, 32'hAAAA, 32'hAAAA, 32'hFFFFFFFD);
        mt(OP_MTLO, 32'h5555, 32'hAAAA, 32'h5555);
        zmode = 1'b1;
        run_op(OP_DIV, 32'd5, 32'd0, 32'hAAAA, 32'h5555, 1, 0, 3, 0);
        zmode = 1'b0;

        mul_lat = 5;
        run_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0, 7, 0);
        // mul_done is still high from the previous MULT during START_MUL.
        mul_lat = 32;
        run_op(OP_MULT, 32'h10000, 32'h10000, 32'd1, 32'd0, 0, 0, 34, 0);

        div_lat = 0;
        run_op(OP_DIV, 32'd9, 32'd3, 32'd1, 32'd0, 0, 1, 42, 1);
        mt(OP_MTLO, 32'h1234, 32'd1, 32'h1234);

        mt(OP_MTHI, 32'd3, 32'd3, 32'h1234);
        send(OP_DIV, 32'd8, 32'd2);
        for (int i = 0; i < 8; i++) tick;
        check("busy", bus.ready, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("mid_rst_ctl", {bus.ready, bus.op_done}, 2'b10);
        check("mid_rst_units", {unit_a, unit_b}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bus.op_done || !bus.ready) seen = 1'b1;
        end
        check("mid_rst_quiet", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
